// File: rtl/rmii_rx_stream_pkg.sv
// Shared definitions for the RMII/MII receive deframer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rmii_rx_stream_pkg;

    // Deframer FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_END   = 3'd4
    } state_t;

    // Start-of-frame delimiter and preamble byte values as seen in the shift window
    localparam logic [7:0] SFD      = 8'hD5;
    localparam logic [7:0] PREAMBLE = 8'h55;

endpackage

// File: rtl/rmii_rx_stream_sample_gen.sv
// Registers Phy pins in clk and produces the accepted-sample enable (100M: every strobe, 10M: 1 in DIV_10M).
// Latency: 1 clk from pins to s_* outputs; sample_en is combinational from the registered strobe.
// Backpressure: none; the Phy cannot be stalled.
module rmii_rx_stream_sample_gen #(
    parameter int DATA_W  = 2,
    parameter int DIV_10M = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rmii_clk,
    input  logic              fast_eth,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              crs_dv,
    input  logic              rx_er,
    input  logic              idle,
    output logic              sample_en,
    output logic [DATA_W-1:0] s_data,
    output logic              s_dv,
    output logic              s_er
);

    localparam int CNT_W = (DIV_10M > 1) ? $clog2(DIV_10M) : 1;

    logic             strobe;
    logic [CNT_W-1:0] dec_cnt;

    // Single register stage on every Phy input; rmii_clk is treated as data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= 1'b0;
            s_data <= '0;
            s_dv   <= 1'b0;
            s_er   <= 1'b0;
        end else begin
            strobe <= rmii_clk;
            s_data <= rx_data;
            s_dv   <= crs_dv;
            s_er   <= rx_er;
        end
    end

    // Strobe decimator for 10M; held at zero while idle without carrier so the
    // first strobe that sees crs_dv is the first accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (idle && !s_dv) begin
            dec_cnt <= '0;
        end else if (strobe) begin
            dec_cnt <= (dec_cnt == CNT_W'(DIV_10M - 1)) ? '0 : dec_cnt + CNT_W'(1);
        end
    end

    // Accept every strobe at 100M, only the counter-zero strobe at 10M
    always_comb begin
        sample_en = strobe && (fast_eth || (dec_cnt == '0));
    end

endmodule

// File: rtl/rmii_rx_stream.sv
// RMII/MII receive deframer: strips preamble/SFD, assembles bytes, emits sof/eof/err/len.
// Latency: byte k is emitted 1 clk after the accepted sample completing byte k+1; last byte rides with eof.
// Backpressure: none; output strobes must be consumed when presented.
import rmii_rx_stream_pkg::*;

module rmii_rx_stream #(
    parameter int DATA_W  = 2,
    parameter int DIV_10M = 10,
    parameter int MAX_LEN = 1536,
    parameter int LEN_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rmii_clk,
    input  logic              fast_eth,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              crs_dv,
    input  logic              rx_er,
    output logic [7:0]        data,
    output logic              valid,
    output logic              sof,
    output logic              eof,
    output logic              err,
    output logic [LEN_W-1:0]  len,
    output logic              busy
);

    state_t             state, state_nxt;
    logic               sample_en;
    logic [DATA_W-1:0]  s_data;
    logic               s_dv;
    logic               s_er;

    logic [7:0]         window;
    logic [7:0]         win_shift;
    logic [2:0]         bit_cnt;
    logic [2:0]         bit_nxt;
    logic [7:0]         hold;
    logic               hold_vld;
    logic [LEN_W-1:0]   byte_cnt;
    logic               err_stk;
    logic               take;
    logic               finish;
    logic               byte_done;
    logic               room;

    rmii_rx_stream_sample_gen #(
        .DATA_W  (DATA_W),
        .DIV_10M (DIV_10M)
    ) u_sample_gen (
        .clk       (clk),
        .rst       (rst),
        .rmii_clk  (rmii_clk),
        .fast_eth  (fast_eth),
        .rx_data   (rx_data),
        .crs_dv    (crs_dv),
        .rx_er     (rx_er),
        .idle      (state == ST_IDLE),
        .sample_en (sample_en),
        .s_data    (s_data),
        .s_dv      (s_dv),
        .s_er      (s_er)
    );

    // Shift/count helpers; the drop sample leaving DATA still carries data (RMII toggle)
    always_comb begin
        win_shift = {s_data, window[7:DATA_W]};
        bit_nxt   = bit_cnt + 3'(DATA_W);
        byte_done = (bit_nxt == 3'd0);
        room      = (byte_cnt < LEN_W'(MAX_LEN));
        take      = sample_en && ((state == ST_DATA) || ((state == ST_DRAIN) && s_dv));
        finish    = sample_en && (state == ST_DRAIN) && !s_dv;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (sample_en && s_dv) state_nxt = ST_PRE;
            ST_PRE: begin
                if (sample_en) begin
                    if (!s_dv)                 state_nxt = ST_IDLE;
                    else if (win_shift == SFD) state_nxt = ST_DATA;
                end
            end
            ST_DATA:  if (sample_en && !s_dv) state_nxt = ST_DRAIN;
            ST_DRAIN: if (sample_en) state_nxt = s_dv ? ST_DATA : ST_END;
            ST_END:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: busy spans SFD detection through the eof cycle (END)
    always_comb begin
        busy = (state == ST_DATA) || (state == ST_DRAIN) || (state == ST_END);
    end

    // Datapath: window, counters, hold register and registered output strobes.
    // eof is registered on the DRAIN->END sample so it is visible during END.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window   <= '0;
            bit_cnt  <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            byte_cnt <= '0;
            err_stk  <= 1'b0;
            data     <= '0;
            valid    <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            err      <= 1'b0;
            len      <= '0;
        end else begin
            data  <= '0;
            valid <= 1'b0;
            sof   <= 1'b0;
            eof   <= 1'b0;
            err   <= 1'b0;
            len   <= '0;

            case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    err_stk  <= 1'b0;
                    hold_vld <= 1'b0;
                    if (sample_en && s_dv) window <= win_shift;
                end
                ST_PRE: begin
                    if (sample_en) window <= s_dv ? win_shift : 8'h00;
                end
                default: ;
            endcase

            if (take) begin
                window  <= win_shift;
                bit_cnt <= bit_nxt;
                if (s_er) err_stk <= 1'b1;
                if (byte_done) begin
                    hold     <= win_shift;
                    hold_vld <= 1'b1;
                    if (hold_vld) begin
                        if (room) begin
                            valid    <= 1'b1;
                            data     <= hold;
                            sof      <= (byte_cnt == '0);
                            byte_cnt <= byte_cnt + LEN_W'(1);
                        end else begin
                            err_stk  <= 1'b1;
                        end
                    end
                end
            end

            if (finish) begin
                eof      <= 1'b1;
                window   <= '0;
                hold_vld <= 1'b0;
                err      <= err_stk | s_er | (bit_cnt != 3'd0) | !(hold_vld && room);
                if (hold_vld && room) begin
                    valid    <= 1'b1;
                    data     <= hold;
                    sof      <= (byte_cnt == '0);
                    len      <= byte_cnt + LEN_W'(1);
                    byte_cnt <= byte_cnt + LEN_W'(1);
                end else begin
                    len      <= byte_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_rmii_rx_stream.sv
// Bench for rmii_rx_stream: RMII (DATA_W=2) and MII (DATA_W=4) instances, directed and random frames.
// Expected output events come from a frame-level model (byte list, trailing symbols, rx_er flag).
// Each frame's final data symbol is driven with crs_dv=0 (the drop sample still carries data); one more 0 ends it.
module tb_rmii_rx_stream;
    import rmii_rx_stream_pkg::*;

    localparam int DIV = 10;
    localparam int MAX = 1536;

    typedef struct {
        logic [7:0] d;
        bit         v;
        bit         s;
        bit         e;
        bit         r;
        int         l;
    } ev_t;

    logic        clk, rst, rmii_clk, fast_eth, crs_dv, rx_er;
    logic [3:0]  rx_d;
    int          sel;
    logic        dv2, dv4, er2, er4;
    logic [7:0]  data2, data4;
    logic        valid2, valid4, sof2, sof4, eof2, eof4, err2, err4, busy2, busy4;
    logic [10:0] len2, len4;

    int          n_checks, n_errors;
    ev_t         expq[2][$];
    logic [7:0]  got[2][$];
    logic [7:0]  fb[$];
    int          last_len[2];
    bit          last_err[2];
    int          eofs[2];

    assign dv2 = crs_dv & (sel == 0);
    assign dv4 = crs_dv & (sel == 1);
    assign er2 = rx_er & (sel == 0);
    assign er4 = rx_er & (sel == 1);

    rmii_rx_stream #(.DATA_W(2), .DIV_10M(DIV), .MAX_LEN(MAX), .LEN_W(11)) u_dut2 (
        .clk(clk), .rst(rst), .rmii_clk(rmii_clk), .fast_eth(fast_eth), .rx_data(rx_d[1:0]),
        .crs_dv(dv2), .rx_er(er2), .data(data2), .valid(valid2), .sof(sof2), .eof(eof2),
        .err(err2), .len(len2), .busy(busy2));

    rmii_rx_stream #(.DATA_W(4), .DIV_10M(DIV), .MAX_LEN(MAX), .LEN_W(11)) u_dut4 (
        .clk(clk), .rst(rst), .rmii_clk(rmii_clk), .fast_eth(fast_eth), .rx_data(rx_d),
        .crs_dv(dv4), .rx_er(er4), .data(data4), .valid(valid4), .sof(sof4), .eof(eof4),
        .err(err4), .len(len4), .busy(busy4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // rmii_clk toggles on clk falling edges, so each high phase is seen by exactly one clk rise
    initial begin
        rmii_clk = 1'b0;
        forever #10 rmii_clk = ~rmii_clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] outs(input int w);
        if (w == 0) return {data2, valid2, sof2, eof2, err2, len2, busy2};
        return {data4, valid4, sof4, eof4, err4, len4, busy4};
    endfunction

    // Compare one instance's output strobes against the head of its expectation queue
    task automatic check_one(input int w, input logic [7:0] d, input logic v, input logic s,
                             input logic e, input logic r, input logic [10:0] l, input logic b);
        ev_t x;
        if (v === 1'b1 || e === 1'b1) begin
            check("busy_with_output", b, 1);
            if (expq[w].size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output dut%0d: valid=%0b eof=%0b data=%0h, expected none", w, v, e, d);
            end else begin
                x = expq[w].pop_front();
                check("valid", v, x.v);
                if (x.v) check("data", d, x.d);
                check("sof", s, x.s);
                check("eof", e, x.e);
                if (x.e) begin
                    check("err", r, x.r);
                    check("len", l, x.l);
                end
            end
            if (v === 1'b1) got[w].push_back(d);
            if (e === 1'b1) begin
                last_len[w] = int'(l);
                last_err[w] = r;
                eofs[w]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check_one(0, data2, valid2, sof2, eof2, err2, len2, busy2);
            check_one(1, data4, valid4, sof4, eof4, err4, len4, busy4);
        end
    end

    // Frame-level model: delivered = first min(n, MAX) bytes; bad if rx_er seen,
    // trailing partial byte, empty, or oversize. eof rides on the last delivered
    // byte unless nothing is left to deliver at the end (empty or oversize).
    task automatic push_expect(input int w, input int n, input int extra, input bit er);
        int  nem;
        bit  bad;
        ev_t x;
        nem = (n > MAX) ? MAX : n;
        bad = er || (extra != 0) || (n == 0) || (n > MAX);
        for (int i = 0; i < nem; i++) begin
            x.d = fb[i];
            x.v = 1'b1;
            x.s = (i == 0);
            x.e = (i == nem - 1) && (n <= MAX);
            x.r = bad;
            x.l = nem;
            expq[w].push_back(x);
        end
        if (n == 0 || n > MAX) begin
            x.d = 8'h00;
            x.v = 1'b0;
            x.s = 1'b0;
            x.e = 1'b1;
            x.r = 1'b1;
            x.l = nem;
            expq[w].push_back(x);
        end
    endtask

    // One Phy symbol, held for one rmii_clk period (100M) or DIV periods (10M)
    task automatic drive(input logic [3:0] sym, input logic dv, input logic er);
        @(posedge rmii_clk);
        rx_d   = sym;
        crs_dv = dv;
        rx_er  = er;
        repeat ((fast_eth ? 1 : DIV) - 1) @(posedge rmii_clk);
    endtask

    task automatic drive_byte(input int w, input logic [7:0] b);
        int wd;
        wd = (w == 1) ? 4 : 2;
        for (int k = 0; k < 8 / wd; k++)
            drive(4'((int'(b) >> (k * wd)) & ((1 << wd) - 1)), 1'b1, 1'b0);
    endtask

    // Send preamble, SFD, fb[0..n-1], then 'extra' random symbols. abort_at >= 0
    // asserts rst instead of driving that data symbol and returns with rst high.
    task automatic send_frame(input int w, input int n, input int extra, input int er_idx,
                              input bit toggle, input int abort_at);
        int         wd, spb, total, e0;
        logic [3:0] q[$];
        logic       dv;
        wd  = (w == 1) ? 4 : 2;
        spb = 8 / wd;
        sel = w;
        got[w].delete();
        e0  = eofs[w];
        push_expect(w, n, extra, er_idx >= 0);
        drive(4'h0, 1'b0, 1'b0);
        drive(4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive_byte(w, PREAMBLE);
        drive_byte(w, SFD);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < spb; k++)
                q.push_back(4'((int'(fb[i]) >> (k * wd)) & ((1 << wd) - 1)));
        for (int i = 0; i < extra; i++) q.push_back(4'($urandom_range(0, (1 << wd) - 1)));
        total = q.size();
        for (int idx = 0; idx < total; idx++) begin
            dv = (idx != total - 1);
            if (toggle && idx >= total - spb) dv = (((total - 1 - idx) % 2) == 1);
            if (idx == abort_at) begin
                @(posedge clk);
                #2;
                rst    = 1'b1;
                crs_dv = 1'b0;
                rx_er  = 1'b0;
                return;
            end
            drive(q[idx], dv, idx == er_idx);
        end
        drive(4'h0, 1'b0, 1'b0);
        drive(4'h0, 1'b0, 1'b0);
        drive(4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 200 && expq[w].size() != 0; k++) @(posedge clk);
        check("frame_drained", expq[w].size(), 0);
        check("eof_count", eofs[w] - e0, 1);
        @(negedge clk);
        check("busy_after_frame", (w == 0) ? busy2 : busy4, 0);
    endtask

    task automatic load_1234();
        fb.delete();
        fb.push_back(8'h01);
        fb.push_back(8'h02);
        fb.push_back(8'h03);
        fb.push_back(8'h04);
    endtask

    task automatic check_1234(input int w, input string tag);
        check({tag, "_count"}, got[w].size(), 4);
        if (got[w].size() == 4) begin
            check({tag, "_b0"}, got[w][0], 8'h01);
            check({tag, "_b3"}, got[w][3], 8'h04);
        end
        check({tag, "_len"}, last_len[w], 4);
        check({tag, "_err"}, last_err[w], 0);
    endtask

    initial begin
        int spb, n, extra, total, er_idx, e0;
        bit tog;
        n_checks = 0;
        n_errors = 0;
        eofs[0] = 0;
        eofs[1] = 0;
        rst      = 1'b1;
        fast_eth = 1'b1;
        crs_dv   = 1'b0;
        rx_er    = 1'b0;
        rx_d     = 4'h0;
        sel      = 0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_outputs_dut2", outs(0), 0);
        check("reset_outputs_dut4", outs(1), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        for (int w = 0; w < 2; w++) begin
            spb = (w == 1) ? 2 : 4;

            fast_eth = 1'b1;
            load_1234();
            send_frame(w, 4, 0, -1, 1'b0, -1);
            check_1234(w, "basic_100m");

            fast_eth = 1'b0;
            send_frame(w, 4, 0, -1, 1'b0, -1);
            check_1234(w, "basic_10m");
            fast_eth = 1'b1;

            fb.delete();
            fb.push_back(8'h11);
            fb.push_back(8'h22);
            fb.push_back(8'hA5);
            send_frame(w, 3, 0, -1, 1'b1, -1);
            check("toggle_count", got[w].size(), 3);
            if (got[w].size() == 3) check("toggle_last", got[w][2], 8'hA5);
            check("toggle_err", last_err[w], 0);

            load_1234();
            send_frame(w, 4, 1, -1, 1'b0, -1);
            check("misalign_err", last_err[w], 1);
            check("misalign_len", last_len[w], 4);

            send_frame(w, 4, 0, spb + 1, 1'b0, -1);
            check("rxer_count", got[w].size(), 4);
            check("rxer_err", last_err[w], 1);

            if (w == 0) begin
                fb.delete();
                for (int i = 0; i < MAX + 5; i++) fb.push_back(8'($urandom));
                send_frame(w, MAX + 5, 0, -1, 1'b0, -1);
                check("oversize_len", last_len[w], MAX);
                check("oversize_err", last_err[w], 1);
                check("oversize_count", got[w].size(), MAX);
            end

            load_1234();
            send_frame(w, 4, 0, -1, 1'b0, 2 * spb + 1);
            #1;
            check("midrst_outputs", outs(w), 0);
            check("midrst_pre_bytes", got[w].size(), 1);
            if (got[w].size() > 0) check("midrst_byte0", got[w][0], 8'h01);
            expq[w].delete();
            e0 = eofs[w];
            repeat (3) @(posedge clk);
            #2 rst = 1'b0;
            drive(4'h0, 1'b0, 1'b0);
            drive(4'h0, 1'b0, 1'b0);
            check("midrst_no_eof", eofs[w] - e0, 0);
            send_frame(w, 4, 0, -1, 1'b0, -1);
            check_1234(w, "after_rst");

            for (int f = 0; f < 10; f++) begin
                fast_eth = 1'($urandom_range(0, 1));
                n = $urandom_range(0, fast_eth ? 40 : 6);
                fb.delete();
                for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
                extra = $urandom_range(0, spb - 1);
                if (n == 0 && extra == 0) extra = 1;
                total  = n * spb + extra;
                er_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
                tog    = (total > spb) ? 1'($urandom_range(0, 1)) : 1'b0;
                send_frame(w, n, extra, er_idx, tog, -1);
            end
            fast_eth = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
